// File: rtl/criterio_geral_if.sv
// Bundles the start request, node snapshot inputs and scan results between
// the global controller (master) and the minimum-criterion scanner (slave).
interface criterio_geral_if #(
    parameter int NUM_NOS        = 4,
    parameter int CRITERIO_WIDTH = 5,
    parameter int IDX_WIDTH      = 2
);
    logic                                ga_iniciar_in;
    logic [NUM_NOS*CRITERIO_WIDTH-1:0]   na_criterio_in;
    logic [NUM_NOS-1:0]                  na_ativo_in;
    logic [CRITERIO_WIDTH-1:0]           ca_criterio_geral_out;
    logic [IDX_WIDTH-1:0]                ca_indice_out;
    logic                                ca_vazio_out;
    logic                                ca_valido_out;
    logic                                ca_ocupado_out;

    modport master (
        output ga_iniciar_in, na_criterio_in, na_ativo_in,
        input  ca_criterio_geral_out, ca_indice_out, ca_vazio_out,
               ca_valido_out, ca_ocupado_out
    );

    modport slave (
        input  ga_iniciar_in, na_criterio_in, na_ativo_in,
        output ca_criterio_geral_out, ca_indice_out, ca_vazio_out,
               ca_valido_out, ca_ocupado_out
    );
endinterface

// File: rtl/criterio_geral.sv
// Iterative minimum finder: snapshots all node criteria on start, compares one
// node per cycle and publishes the smallest active criterion and its index.
module criterio_geral #(
    parameter int NUM_NOS        = 4,
    parameter int CRITERIO_WIDTH = 5,
    parameter int IDX_WIDTH      = 2
) (
    input  logic             clk,
    input  logic             rst,
    criterio_geral_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [CRITERIO_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [IDX_WIDTH-1:0]      LAST     = IDX_WIDTH'(NUM_NOS - 1);

    state_t                                   state_q, state_d;
    logic [NUM_NOS-1:0][CRITERIO_WIDTH-1:0]   snap_crit_q, snap_crit_d;
    logic [NUM_NOS-1:0]                       snap_ativo_q, snap_ativo_d;
    logic [CRITERIO_WIDTH-1:0]                min_q, min_d;
    logic [IDX_WIDTH-1:0]                     idx_q, idx_d;
    logic                                     found_q, found_d;
    logic [IDX_WIDTH-1:0]                     cnt_q, cnt_d;
    logic [CRITERIO_WIDTH-1:0]                crit_out_q, crit_out_d;
    logic [IDX_WIDTH-1:0]                     indice_q, indice_d;
    logic                                     vazio_q, vazio_d;
    logic                                     valido_q, valido_d;
    logic [CRITERIO_WIDTH-1:0]                entry;
    logic                                     hit;

    always_comb begin
        state_d      = state_q;
        snap_crit_d  = snap_crit_q;
        snap_ativo_d = snap_ativo_q;
        min_d        = min_q;
        idx_d        = idx_q;
        found_d      = found_q;
        cnt_d        = cnt_q;
        crit_out_d   = crit_out_q;
        indice_d     = indice_q;
        vazio_d      = vazio_q;
        valido_d     = 1'b0;

        entry = snap_crit_q[cnt_q];
        // strict compare: earlier index keeps ties, all-ones can never win
        hit   = snap_ativo_q[cnt_q] && (entry < min_q);

        case (state_q)
            IDLE: begin
                if (bus.ga_iniciar_in) begin
                    snap_crit_d  = bus.na_criterio_in;
                    snap_ativo_d = bus.na_ativo_in;
                    min_d        = ALL_ONES;
                    idx_d        = '0;
                    found_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    min_d   = entry;
                    idx_d   = cnt_q;
                    found_d = 1'b1;
                end
                // results load on entry to DONE so they appear with the valid pulse
                if (cnt_q == LAST) begin
                    crit_out_d = min_d;
                    indice_d   = idx_d;
                    vazio_d    = !found_d;
                    valido_d   = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_crit_q  <= '0;
            snap_ativo_q <= '0;
            min_q        <= ALL_ONES;
            idx_q        <= '0;
            found_q      <= 1'b0;
            cnt_q        <= '0;
            crit_out_q   <= ALL_ONES;
            indice_q     <= '0;
            vazio_q      <= 1'b0;
            valido_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_crit_q  <= snap_crit_d;
            snap_ativo_q <= snap_ativo_d;
            min_q        <= min_d;
            idx_q        <= idx_d;
            found_q      <= found_d;
            cnt_q        <= cnt_d;
            crit_out_q   <= crit_out_d;
            indice_q     <= indice_d;
            vazio_q      <= vazio_d;
            valido_q     <= valido_d;
        end
    end

    assign bus.ca_criterio_geral_out = crit_out_q;
    assign bus.ca_indice_out         = indice_q;
    assign bus.ca_vazio_out          = vazio_q;
    assign bus.ca_valido_out         = valido_q;
    assign bus.ca_ocupado_out        = (state_q != IDLE);
endmodule

// File: tb/tb_criterio_geral.sv
// Directed bench for criterio_geral: table of scans plus reset, busy/snapshot
// and back-to-back start sequences.
module tb_criterio_geral;
    localparam int NN = 4;
    localparam int CW = 5;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    criterio_geral_if #(.NUM_NOS(NN), .CRITERIO_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

    criterio_geral #(.NUM_NOS(NN), .CRITERIO_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NN-1:0]         ativo;
        logic [NN*CW-1:0]      crit;
        int                    e_crit;
        int                    e_idx;
        int                    e_vazio;
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [NN*CW-1:0] mk(int n0, int n1, int n2, int n3);
        logic [4:0] a, b, c, d;
        a = n0[4:0]; b = n1[4:0]; c = n2[4:0]; d = n3[4:0];
        return {d, c, b, a};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_crit"},   int'(bus.ca_criterio_geral_out), 31);
        chk({tag, "_idx"},    int'(bus.ca_indice_out), 0);
        chk({tag, "_vazio"},  int'(bus.ca_vazio_out), 0);
        chk({tag, "_valido"}, int'(bus.ca_valido_out), 0);
        chk({tag, "_ocup"},   int'(bus.ca_ocupado_out), 0);
    endtask

    // One start pulse; watches 8 cycles after the accept edge (k=1 is c+1).
    task automatic run_scan(input vec_t v, input int n);
        int first_valid, nvalid, busy_err;
        first_valid = -1; nvalid = 0; busy_err = 0;
        @(negedge clk);
        bus.na_ativo_in    = v.ativo;
        bus.na_criterio_in = v.crit;
        bus.ga_iniciar_in  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.ga_iniciar_in = 1'b0;
            if (bus.ca_valido_out) begin
                nvalid++;
                if (first_valid < 0) first_valid = k;
            end
            if (bus.ca_ocupado_out != (k <= NN + 1)) busy_err++;
            if (k == NN + 1) begin
                chk($sformatf("v%0d_crit", n),  int'(bus.ca_criterio_geral_out), v.e_crit);
                chk($sformatf("v%0d_idx", n),   int'(bus.ca_indice_out), v.e_idx);
                chk($sformatf("v%0d_vazio", n), int'(bus.ca_vazio_out), v.e_vazio);
            end
        end
        chk($sformatf("v%0d_valid_cycle", n), first_valid, NN + 1);
        chk($sformatf("v%0d_valid_count", n), nvalid, 1);
        chk($sformatf("v%0d_busy_errs", n), busy_err, 0);
        // results must hold after the pulse
        chk($sformatf("v%0d_hold_crit", n), int'(bus.ca_criterio_geral_out), v.e_crit);
    endtask

    initial begin
        int nvalid, busy_err, bad_valid;

        vecs[0] = '{4'b1111, mk(9, 3, 7, 12),  3, 1, 0};
        vecs[1] = '{4'b1010, mk(1, 6, 1, 6),   6, 1, 0};
        vecs[2] = '{4'b0000, mk(2, 2, 2, 2),  31, 0, 1};
        vecs[3] = '{4'b0001, mk(31, 0, 0, 0), 31, 0, 1};
        vecs[4] = '{4'b1111, mk(5, 5, 5, 5),   5, 0, 0};
        vecs[5] = '{4'b1000, mk(0, 0, 0, 30), 30, 3, 0};
        vecs[6] = '{4'b0110, mk(0, 31, 4, 0),  4, 2, 0};

        bus.ga_iniciar_in  = 1'b0;
        bus.na_ativo_in    = '0;
        bus.na_criterio_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_scan(vecs[i], i);

        // reset mid-scan aborts and suppresses the valid pulse
        @(negedge clk);
        bus.na_ativo_in    = 4'b1111;
        bus.na_criterio_in = mk(9, 3, 7, 12);
        bus.ga_iniciar_in  = 1'b1;
        @(negedge clk);
        bus.ga_iniciar_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("rst_mid");
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ca_valido_out) nvalid++;
        end
        chk("rst_mid_no_valid", nvalid, 0);
        chk("rst_mid_idle", int'(bus.ca_ocupado_out), 0);

        // second start at c+2 is ignored; new inputs at c+2 must not leak in
        @(negedge clk);
        bus.na_ativo_in    = 4'b1111;
        bus.na_criterio_in = mk(9, 3, 7, 12);
        bus.ga_iniciar_in  = 1'b1;
        @(posedge clk);
        nvalid = 0; busy_err = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.ga_iniciar_in = (k == 2);
            if (k == 2) begin
                bus.na_ativo_in    = 4'b0001;
                bus.na_criterio_in = mk(0, 0, 0, 0);
            end
            if (bus.ca_valido_out) nvalid++;
            if (bus.ca_ocupado_out != (k <= 5)) busy_err++;
            if (k == 5) begin
                chk("snap_valid", int'(bus.ca_valido_out), 1);
                chk("snap_crit", int'(bus.ca_criterio_geral_out), 3);
                chk("snap_idx", int'(bus.ca_indice_out), 1);
                chk("snap_vazio", int'(bus.ca_vazio_out), 0);
            end
        end
        chk("snap_valid_count", nvalid, 1);
        chk("snap_busy_errs", busy_err, 0);

        // start held high: accepts at c, c+6, c+12; valid at c+5, c+11, c+17
        @(negedge clk);
        bus.na_ativo_in    = 4'b1010;
        bus.na_criterio_in = mk(1, 6, 1, 6);
        bus.ga_iniciar_in  = 1'b1;
        @(posedge clk);
        nvalid = 0; bad_valid = 0; busy_err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 17) bus.ga_iniciar_in = 1'b0;
            if (bus.ca_valido_out) begin
                nvalid++;
                if (!(k == 5 || k == 11 || k == 17)) bad_valid++;
            end
            if (bus.ca_ocupado_out != !(k == 6 || k == 12 || k >= 18)) busy_err++;
        end
        chk("b2b_valid_count", nvalid, 3);
        chk("b2b_valid_misplaced", bad_valid, 0);
        chk("b2b_busy_errs", busy_err, 0);
        chk("b2b_crit", int'(bus.ca_criterio_geral_out), 6);
        chk("b2b_idx", int'(bus.ca_indice_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
